en_tick_sched: RTL and testbench

Programmable enable-strobe scheduler for slow subsystems built from enable-gated registers. It divides `clk` by a configurable period and emits single-cycle `tick` strobes to drive the `en` inputs of slow-domain flip-flops, keeping them synchronous with the fast clock. It runs either continuously or for a fixed burst of ticks, under a start/stop/config control interface. It sits between the system controller and any bank of enable-gated registers.

---
 rtl/en_tick_sched_pkg.sv | 25 ++
 rtl/en_tick_sched_phase_counter.sv | 42 ++++
 rtl/en_tick_sched.sv | 146 ++++++++++++++
 tb/tb_en_tick_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/en_tick_sched_pkg.sv
// ============================================================================
// Module      : en_tick_sched_pkg
// Description : Shared definitions for the enable-strobe scheduler: default
//               widths and the scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package en_tick_sched_pkg;

  // Default width of the period divisor
  localparam int DW_DEFAULT = 16;
  // Default width of the burst count and tick counter
  localparam int CW_DEFAULT = 8;

  // Scheduler states: IDLE=0, RUN=1, DONE=2
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : en_tick_sched_pkg

`default_nettype wire

// File: rtl/en_tick_sched_phase_counter.sv
// ============================================================================
// Module      : tick_phase_counter
// Description : Modulo-div phase counter. Counts 0..div-1 while enabled and
//               flags the terminal phase on tc. clr forces phase 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_phase_counter
  import en_tick_sched_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] div,
  output logic          tc
);

  localparam logic [DW-1:0] C_ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] r_ph;

  // Terminal phase is div-1; div is never 0 because the owner clamps it
  assign tc = (r_ph == (div - C_ONE));

  // Phase register: clear has priority, otherwise wrap at the terminal phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph <= '0;
    end else if (clr) begin
      r_ph <= '0;
    end else if (en) begin
      r_ph <= tc ? '0 : (r_ph + C_ONE);
    end
  end

endmodule : tick_phase_counter

`default_nettype wire

// File: rtl/en_tick_sched.sv
// ============================================================================
// Module      : en_tick_sched
// Description : Programmable enable-strobe scheduler. Divides clk by a
//               configurable period and issues registered one-cycle tick
//               strobes, continuously or for a fixed burst, under a
//               start/stop/config control interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module en_tick_sched
  import en_tick_sched_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_div,
  input  logic [CW-1:0] cfg_count,
  input  logic          start,
  input  logic          stop,
  output logic          tick,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] tick_cnt
);

  localparam logic [DW-1:0] C_DIV_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tick_cnt;
  logic          r_tick;

  logic          w_cfg_accept;
  logic          w_start_run;
  logic          w_tick_nxt;
  logic          w_cnt_inc;
  logic          w_ph_clr;
  logic          w_ph_en;
  logic          w_tc;
  logic [CW-1:0] w_tick_cnt_inc;
  logic [DW-1:0] w_div_eff;

  // A zero divisor behaves as divide-by-one
  assign w_div_eff      = (cfg_div == '0) ? C_DIV_ONE : cfg_div;
  assign w_tick_cnt_inc = r_tick_cnt + C_CNT_ONE;

  tick_phase_counter #(
    .DW (DW)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .clr   (w_ph_clr),
    .en    (w_ph_en),
    .div   (r_div),
    .tc    (w_tc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; stop in RUN suppresses the pending tick
  always_comb begin
    w_state_nxt  = r_state;
    w_cfg_accept = 1'b0;
    w_start_run  = 1'b0;
    w_tick_nxt   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_ph_clr     = 1'b0;
    w_ph_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_accept = cfg_valid;
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
          w_start_run = 1'b1;
          w_ph_clr    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ph_en = 1'b1;
          if (w_tc) begin
            w_tick_nxt = 1'b1;
            w_cnt_inc  = 1'b1;
            if ((r_cnt != '0) && (w_tick_cnt_inc == r_cnt)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Config registers, tick counter and the registered strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= C_DIV_ONE;
      r_cnt      <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (w_cfg_accept) begin
        r_div <= w_div_eff;
        r_cnt <= cfg_count;
      end
      if (w_start_run) begin
        r_tick_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_tick_cnt <= w_tick_cnt_inc;
      end
      r_tick <= w_tick_nxt;
    end
  end

  assign tick      = r_tick;
  assign tick_cnt  = r_tick_cnt;
  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);

endmodule : en_tick_sched

`default_nettype wire

// File: tb/tb_en_tick_sched.sv
// ============================================================================
// Module      : tb_en_tick_sched
// Description : Scoreboard bench for en_tick_sched. A reference model predicts
//               every post-edge output from elapsed-time arithmetic; a monitor
//               compares the DUT against the queued predictions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_en_tick_sched;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_div;
  logic [CW-1:0] cfg_count;
  logic          start;
  logic          stop;
  logic          tick;
  logic          busy;
  logic          done;
  logic [CW-1:0] tick_cnt;

  en_tick_sched #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_count (cfg_count),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tick;
    logic          busy;
    logic          done;
    logic          rdy;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0=idle 1=run 2=done; ticks occur at edges e0+k*div
  int     m_mode;
  longint m_div;
  longint m_cnt;
  longint m_e0;
  longint m_cyc = 0;
  longint m_tcnt;
  logic   m_tick;

  task automatic model_reset();
    m_mode = 0;
    m_div  = 1;
    m_cnt  = 0;
    m_tick = 1'b0;
    m_tcnt = 0;
  endtask

  task automatic model_step();
    longint k;
    case (m_mode)
      0: begin
        m_tick = 1'b0;
        if (cfg_valid) begin
          m_div = (cfg_div == 0) ? 1 : longint'(cfg_div);
          m_cnt = longint'(cfg_count);
        end
        if (start && !stop) begin
          m_mode = 1;
          m_e0   = m_cyc;
          m_tcnt = 0;
        end
      end
      1: begin
        if (stop) begin
          m_mode = 0;
          m_tick = 1'b0;
        end else begin
          k = m_cyc - m_e0;
          if (k % m_div == 0) begin
            m_tick = 1'b1;
            m_tcnt = k / m_div;
            if (m_cnt != 0 && m_tcnt == m_cnt) m_mode = 2;
          end else begin
            m_tick = 1'b0;
          end
        end
      end
      default: begin
        m_mode = 0;
        m_tick = 1'b0;
      end
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.tick = m_tick;
    o.busy = (m_mode == 1);
    o.done = (m_mode == 2);
    o.rdy  = (m_mode == 0);
    o.cnt  = CW'(m_tcnt);
    return o;
  endfunction

  // Prediction process: evaluates the model at every edge from sampled inputs
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      m_cyc++;
      if (reset) model_reset();
      else model_step();
      exp_q.push_back(model_obs());
    end
  end

  // Monitor: compares DUT outputs against the oldest prediction after each edge
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      a = '{tick: tick, busy: busy, done: done, rdy: cfg_ready, cnt: tick_cnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty t=%0t actual=%h", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t actual tick=%b busy=%b done=%b rdy=%b cnt=%0d required tick=%b busy=%b done=%b rdy=%b cnt=%0d",
                   $time, a.tick, a.busy, a.done, a.rdy, a.cnt,
                   e.tick, e.busy, e.done, e.rdy, e.cnt);
        end
      end
    end
  end

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if ({tick, busy, done, cfg_ready, tick_cnt} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL %s actual tick=%b busy=%b done=%b rdy=%b cnt=%0d required 0 0 0 1 0",
               name, tick, busy, done, cfg_ready, tick_cnt);
    end
  endtask

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    logic found;
    reset     = 1'b1;
    cfg_div   = '0;
    cfg_count = '0;
    idle_inputs();
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Burst of three ticks with period four
    @(negedge clk);
    cfg_valid = 1'b1; cfg_div = 16'd4; cfg_count = 8'd3;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);

    // Divide-by-zero continuous run, stopped after ten cycles
    cfg_valid = 1'b1; cfg_div = 16'd0; cfg_count = 8'd0; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    repeat (9) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);

    // Config offer during RUN is refused, accepted once back in IDLE
    cfg_valid = 1'b1; cfg_div = 16'd3; cfg_count = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_div = 16'd7; cfg_count = 8'd2;
    repeat (8) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);

    // start and stop together in IDLE, then start with a same-cycle config
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; cfg_valid = 1'b1; cfg_div = 16'd2; cfg_count = 8'd2;
    @(negedge clk);
    idle_inputs();
    repeat (8) @(negedge clk);

    // Stop exactly on the terminal phase of the first period
    cfg_valid = 1'b1; cfg_div = 16'd5; cfg_count = 8'd0; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while a tick is high, then a default-config run (divide by one)
    cfg_valid = 1'b1; cfg_div = 16'd3; cfg_count = 8'd5; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (m_tick) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL tick_wait_timeout actual no tick in 50 cycles required tick");
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_burst");
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 499) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = DW'($urandom_range(0, 6));
      cfg_count = CW'($urandom_range(0, 4));
      start     = ($urandom_range(0, 4) == 0);
      stop      = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_en_tick_sched

`default_nettype wire
